// File: rtl/lsu_ecc_scrub_ctl_pkg.sv
// Shared types and constants for the DCCM ECC scrub controller.
//   scrub_state_t     : scrubber FSM states
//   SCRUB_ADDR_W_DFLT : default DCCM byte-address width (from RV_DCCM_BITS)
//   ECC_MASK          : data-bit masks for the six Hamming check bits
`ifndef RV_DCCM_BITS
`define RV_DCCM_BITS 16
`endif

package lsu_ecc_scrub_ctl_pkg;

    localparam int SCRUB_ADDR_W_DFLT = `RV_DCCM_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } scrub_state_t;

    // Check bit k covers the data bits whose Hamming position has bit k set.
    localparam logic [5:0][31:0] ECC_MASK = {
        32'hFC000000,
        32'h03FFF800,
        32'h03FC07F0,
        32'hE3C3C78E,
        32'h9B33366D,
        32'h56AAAD5B
    };

endpackage

// File: rtl/lsu_ecc_scrub_ctl_q.sv
// Pending-correction queue for the ECC scrubber (module lsu_ecc_scrub_q).
// Entries are kept compacted so slot 0 is always the oldest (head).
// Each cycle: drop the popped head and killed entries, then apply the lo push,
// then the hi push. A push whose word address is already queued only updates data.
// Ports:
//   i_clk, i_rst_l                : clock, async active-low reset
//   i_push_lo/hi, i_waddr_*, i_data_* : capture requests (word address, corrected data)
//   i_pop                         : head written back this cycle
//   i_kill, i_kill_waddr          : invalidate entries matching a stbuf drain write
//   o_head_valid/waddr/data       : oldest entry
//   o_nonempty_nxt                : queue will hold an entry next cycle
//   o_accept[1:0]                 : lo/hi push was stored or merged
//   o_drop                        : a push found no free slot
module lsu_ecc_scrub_q #(
    parameter int DEPTH = 2,
    parameter int WA_W  = 14
) (
    input  logic            i_clk,
    input  logic            i_rst_l,
    input  logic            i_push_lo,
    input  logic [WA_W-1:0] i_waddr_lo,
    input  logic [31:0]     i_data_lo,
    input  logic            i_push_hi,
    input  logic [WA_W-1:0] i_waddr_hi,
    input  logic [31:0]     i_data_hi,
    input  logic            i_pop,
    input  logic            i_kill,
    input  logic [WA_W-1:0] i_kill_waddr,
    output logic            o_head_valid,
    output logic [WA_W-1:0] o_head_waddr,
    output logic [31:0]     o_head_data,
    output logic            o_nonempty_nxt,
    output logic [1:0]      o_accept,
    output logic            o_drop
);

    typedef struct packed {
        logic            valid;
        logic [WA_W-1:0] waddr;
        logic [31:0]     data;
    } entry_t;

    entry_t          r_q   [DEPTH];
    entry_t          w_nxt [DEPTH];
    logic [1:0]      w_push;
    logic [WA_W-1:0] w_pw  [2];
    logic [31:0]     w_pd  [2];
    int              w_fill;
    logic            w_hit;

    // A capture to an address being overwritten by the stbuf drain is stale.
    assign w_push[0] = i_push_lo & ~(i_kill & (i_waddr_lo == i_kill_waddr));
    assign w_push[1] = i_push_hi & ~(i_kill & (i_waddr_hi == i_kill_waddr));
    assign w_pw[0]   = i_waddr_lo;
    assign w_pw[1]   = i_waddr_hi;
    assign w_pd[0]   = i_data_lo;
    assign w_pd[1]   = i_data_hi;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) w_nxt[i] = '0;
        w_fill   = 0;
        w_hit    = 1'b0;
        o_accept = '0;
        o_drop   = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (r_q[i].valid && !(i_pop && i == 0) &&
                !(i_kill && r_q[i].waddr == i_kill_waddr)) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == w_fill) w_nxt[j] = r_q[i];
                end
                w_fill++;
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
                w_hit = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_nxt[i].valid && w_nxt[i].waddr == w_pw[p]) begin
                        w_nxt[i].data = w_pd[p];
                        w_hit         = 1'b1;
                    end
                end
                if (w_hit) begin
                    o_accept[p] = 1'b1;
                end else if (w_fill < DEPTH) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == w_fill) w_nxt[j] = '{valid: 1'b1, waddr: w_pw[p], data: w_pd[p]};
                    end
                    w_fill++;
                    o_accept[p] = 1'b1;
                end else begin
                    o_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_q[i] <= w_nxt[i];
        end
    end

    assign o_head_valid   = r_q[0].valid;
    assign o_head_waddr   = r_q[0].waddr;
    assign o_head_data    = r_q[0].data;
    assign o_nonempty_nxt = w_nxt[0].valid;

endmodule

// File: rtl/rvecc_encode.sv
// SEC-DED encoder for a 32-bit DCCM word: 6 Hamming check bits plus overall parity.
// Ports:
//   i_din : data word
//   o_ecc : 7-bit ECC ([6] = overall parity of data and check bits)
module rvecc_encode
    import lsu_ecc_scrub_ctl_pkg::*;
(
    input  logic [31:0] i_din,
    output logic [6:0]  o_ecc
);

    logic [5:0] w_chk;

    for (genvar k = 0; k < 6; k++) begin : g_chk
        assign w_chk[k] = ^(i_din & ECC_MASK[k]);
    end

    assign o_ecc = {^{i_din, w_chk}, w_chk};

endmodule

// File: rtl/lsu_ecc_scrub_ctl.sv
// DCCM ECC scrub controller: captures single-bit-corrected load data in dc3,
// queues it, and writes the re-encoded word back when the DCCM write port is
// free. Requests a stbuf/read stall if the port stays busy too long.
// Optional macro RV_ECC_SCRUB_CNT_EN adds a saturating corrected-error counter
// (parameter CNT_W, port o_ecc_scrub_err_cnt).
// Ports:
//   i_clk, i_rst_l                    : clock, async active-low reset
//   i_ld_valid_dc3                    : DCCM load in dc3
//   i_lsu_addr_dc3 / i_end_addr_dc3   : lo / hi bank byte address
//   i_single_ecc_error_lo/hi_dc3      : SEC per bank
//   i_store_ecc_datafn_lo/hi_dc3      : corrected data per bank
//   i_dec_tlu_core_ecc_disable        : block new captures
//   i_stbuf_wr_dccm, i_stbuf_addr_any : stbuf drain write
//   i_dccm_port_busy                  : other DCCM access
//   o_ecc_scrub_wren/addr/wr_data/wr_ecc : write-back port
//   o_ecc_scrub_stall_req             : hold stbuf drain / new reads
//   o_ecc_scrub_pending               : queue non-empty
//   o_ecc_scrub_drop                  : pulse the cycle after a capture was discarded
//   o_ecc_scrub_err_cnt               : corrected-error count (macro only)
//
// state | meaning
// IDLE  | queue empty
// WAIT  | entries queued, waiting for a free write port
// STALL | starved for STARVE_CYC cycles, stall requested
module lsu_ecc_scrub_ctl
    import lsu_ecc_scrub_ctl_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int ADDR_W     = SCRUB_ADDR_W_DFLT,
    parameter int STARVE_CYC = 16
`ifdef RV_ECC_SCRUB_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_l,
    input  logic              i_ld_valid_dc3,
    input  logic [ADDR_W-1:0] i_lsu_addr_dc3,
    input  logic [ADDR_W-1:0] i_end_addr_dc3,
    input  logic              i_single_ecc_error_lo_dc3,
    input  logic              i_single_ecc_error_hi_dc3,
    input  logic [31:0]       i_store_ecc_datafn_lo_dc3,
    input  logic [31:0]       i_store_ecc_datafn_hi_dc3,
    input  logic              i_dec_tlu_core_ecc_disable,
    input  logic              i_stbuf_wr_dccm,
    input  logic [ADDR_W-1:0] i_stbuf_addr_any,
    input  logic              i_dccm_port_busy,
    output logic              o_ecc_scrub_wren,
    output logic [ADDR_W-1:0] o_ecc_scrub_addr,
    output logic [31:0]       o_ecc_scrub_wr_data,
    output logic [6:0]        o_ecc_scrub_wr_ecc,
    output logic              o_ecc_scrub_stall_req,
    output logic              o_ecc_scrub_pending,
    output logic              o_ecc_scrub_drop
`ifdef RV_ECC_SCRUB_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_ecc_scrub_err_cnt
`endif
);

    localparam int WA_W = ADDR_W - 2;
    localparam int WC_W = $clog2(STARVE_CYC + 1);

    scrub_state_t    r_state, w_state_nxt;
    logic [WC_W-1:0] r_wait_cnt, w_wait_nxt;
    logic            r_drop;
    logic            w_cap_lo, w_cap_hi, w_grant, w_pop;
    logic            w_head_valid, w_nonempty_nxt, w_drop;
    logic [WA_W-1:0] w_head_waddr;
    logic [31:0]     w_head_data;
    logic [1:0]      w_accept;
    logic            w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^{i_lsu_addr_dc3[1:0], i_end_addr_dc3[1:0], i_stbuf_addr_any[1:0]};

    assign w_cap_lo = i_ld_valid_dc3 & ~i_dec_tlu_core_ecc_disable & i_single_ecc_error_lo_dc3;
    assign w_cap_hi = i_ld_valid_dc3 & ~i_dec_tlu_core_ecc_disable & i_single_ecc_error_hi_dc3;
    assign w_grant  = ~i_stbuf_wr_dccm & ~i_dccm_port_busy;
    // Kept out of the FSM process so the queue's next-state feedback is a clean chain.
    assign w_pop    = (r_state != IDLE) & w_grant & w_head_valid;

    lsu_ecc_scrub_q #(
        .DEPTH (DEPTH),
        .WA_W  (WA_W)
    ) u_q (
        .i_clk          (i_clk),
        .i_rst_l        (i_rst_l),
        .i_push_lo      (w_cap_lo),
        .i_waddr_lo     (i_lsu_addr_dc3[ADDR_W-1:2]),
        .i_data_lo      (i_store_ecc_datafn_lo_dc3),
        .i_push_hi      (w_cap_hi),
        .i_waddr_hi     (i_end_addr_dc3[ADDR_W-1:2]),
        .i_data_hi      (i_store_ecc_datafn_hi_dc3),
        .i_pop          (w_pop),
        .i_kill         (i_stbuf_wr_dccm),
        .i_kill_waddr   (i_stbuf_addr_any[ADDR_W-1:2]),
        .o_head_valid   (w_head_valid),
        .o_head_waddr   (w_head_waddr),
        .o_head_data    (w_head_data),
        .o_nonempty_nxt (w_nonempty_nxt),
        .o_accept       (w_accept),
        .o_drop         (w_drop)
    );

    rvecc_encode u_ecc (
        .i_din (w_head_data),
        .o_ecc (o_ecc_scrub_wr_ecc)
    );

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_drop     <= w_drop;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            IDLE: begin
                w_wait_nxt = '0;
                if (w_nonempty_nxt) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_grant) begin
                    w_wait_nxt = '0;
                end else if (r_wait_cnt == WC_W'(STARVE_CYC - 1)) begin
                    w_state_nxt = STALL;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            STALL: begin
                if (w_grant) begin
                    w_state_nxt = WAIT;
                    w_wait_nxt  = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Covers both the last pop and a kill that empties the queue.
        if (!w_nonempty_nxt) begin
            w_state_nxt = IDLE;
            w_wait_nxt  = '0;
        end
    end

    assign o_ecc_scrub_wren      = w_pop;
    assign o_ecc_scrub_addr      = {w_head_waddr, 2'b00};
    assign o_ecc_scrub_wr_data   = w_head_data;
    assign o_ecc_scrub_stall_req = (r_state == STALL);
    assign o_ecc_scrub_pending   = w_head_valid;
    assign o_ecc_scrub_drop      = r_drop;

`ifdef RV_ECC_SCRUB_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W:0]   w_cnt_sum;

    // One spare bit catches overflow; +2 from all-ones cannot wrap past it.
    assign w_cnt_sum = {1'b0, r_err_cnt} + (CNT_W+1)'(w_accept[0]) + (CNT_W+1)'(w_accept[1]);

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) r_err_cnt <= '0;
        else          r_err_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end

    assign o_ecc_scrub_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_lsu_ecc_scrub_ctl.sv
module tb_lsu_ecc_scrub_ctl;

    localparam int ADDR_W = 16;
    localparam int NV     = 8;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        ld_valid, err_lo, err_hi, ecc_dis, stbuf_wr, busy;
    logic [15:0] lsu_addr, end_addr, stbuf_addr;
    logic [31:0] data_lo, data_hi;
    logic        wren, stall, pending, drop;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  wr_ecc;
`ifdef RV_ECC_SCRUB_CNT_EN
    logic [1:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    lsu_ecc_scrub_ctl #(
        .DEPTH      (2),
        .ADDR_W     (ADDR_W),
        .STARVE_CYC (16)
`ifdef RV_ECC_SCRUB_CNT_EN
        ,
        .CNT_W      (2)
`endif
    ) dut (
        .i_clk                      (clk),
        .i_rst_l                    (rst_l),
        .i_ld_valid_dc3             (ld_valid),
        .i_lsu_addr_dc3             (lsu_addr),
        .i_end_addr_dc3             (end_addr),
        .i_single_ecc_error_lo_dc3  (err_lo),
        .i_single_ecc_error_hi_dc3  (err_hi),
        .i_store_ecc_datafn_lo_dc3  (data_lo),
        .i_store_ecc_datafn_hi_dc3  (data_hi),
        .i_dec_tlu_core_ecc_disable (ecc_dis),
        .i_stbuf_wr_dccm            (stbuf_wr),
        .i_stbuf_addr_any           (stbuf_addr),
        .i_dccm_port_busy           (busy),
        .o_ecc_scrub_wren           (wren),
        .o_ecc_scrub_addr           (wr_addr),
        .o_ecc_scrub_wr_data        (wr_data),
        .o_ecc_scrub_wr_ecc         (wr_ecc),
        .o_ecc_scrub_stall_req      (stall),
        .o_ecc_scrub_pending        (pending),
        .o_ecc_scrub_drop           (drop)
`ifdef RV_ECC_SCRUB_CNT_EN
        ,
        .o_ecc_scrub_err_cnt        (err_cnt)
`endif
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        ld_valid, dis, lo, hi;
        logic [15:0] addr, eaddr;
        logic [31:0] dl, dh;
        int          n;
        logic [15:0] ea0, ea1;
        logic [31:0] ed0, ed1;
    } vec_t;

    wr_t  sb[$];
    wr_t  m_exp;
    vec_t vecs[NV];
    int   checks = 0;
    int   errors = 0;

    // Hamming SEC-DED reference: data bits occupy the non-power-of-two positions 3,5,6,7,9,...
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [6:0] e;
        int         di;
        e  = '0;
        di = 0;
        for (int pos = 3; pos < 40; pos++) begin
            if (((pos & (pos - 1)) != 0) && di < 32) begin
                for (int k = 0; k < 6; k++) if (pos[k]) e[k] = e[k] ^ d[di];
                di++;
            end
        end
        e[6] = ^{d, e[5:0]};
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_l && wren) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wren: got write to %h, expected none", wr_addr);
            end else begin
                m_exp = sb.pop_front();
                check("wr_addr", {16'h0, wr_addr}, {16'h0, m_exp.addr});
                check("wr_data", wr_data, m_exp.data);
                check("wr_ecc", {25'h0, wr_ecc}, {25'h0, ref_ecc(m_exp.data)});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ld_valid = 0; err_lo = 0; err_hi = 0; ecc_dis = 0; stbuf_wr = 0; busy = 0;
        lsu_addr = '0; end_addr = '0; stbuf_addr = '0; data_lo = '0; data_hi = '0;
    endtask

    task automatic cap_lo(input logic [15:0] a, input logic [31:0] d);
        ld_valid = 1; err_lo = 1; err_hi = 0; lsu_addr = a; end_addr = a + 16'd3; data_lo = d;
    endtask

    task automatic no_cap();
        ld_valid = 0; err_lo = 0; err_hi = 0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [31:0] d);
        sb.push_back('{addr: a, data: d});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d writes outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst_l = 0;
        clear_inputs();
        sb.delete();
        repeat (2) @(negedge clk);
        check("rst_wren", {31'h0, wren}, 0);
        check("rst_addr", {16'h0, wr_addr}, 0);
        check("rst_data", wr_data, 0);
        check("rst_ecc", {25'h0, wr_ecc}, 0);
        check("rst_stall", {31'h0, stall}, 0);
        check("rst_pending", {31'h0, pending}, 0);
        check("rst_drop", {31'h0, drop}, 0);
`ifdef RV_ECC_SCRUB_CNT_EN
        check("rst_cnt", {30'h0, err_cnt}, 0);
`endif
        cyc();
        rst_l = 1;
    endtask

    initial begin
        clear_inputs();
        // ld_valid dis lo hi addr eaddr dl dh n ea0 ea1 ed0 ed1
        vecs[0] = '{1, 0, 1, 0, 16'h0104, 16'h0107, 32'hDEADBEEF, 32'h0, 1, 16'h0104, 16'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1, 0, 1, 1, 16'h0106, 16'h0109, 32'h12345678, 32'h9ABCDEF0, 2, 16'h0104, 16'h0108, 32'h12345678, 32'h9ABCDEF0};
        vecs[2] = '{1, 0, 0, 1, 16'h0202, 16'h0205, 32'h0, 32'h0F0F0F0F, 1, 16'h0204, 16'h0, 32'h0F0F0F0F, 32'h0};
        vecs[3] = '{1, 1, 1, 0, 16'h0110, 16'h0113, 32'hCAFEF00D, 32'h0, 0, 16'h0, 16'h0, 32'h0, 32'h0};
        vecs[4] = '{1, 0, 1, 1, 16'h0300, 16'h0303, 32'h11111111, 32'h22222222, 1, 16'h0300, 16'h0, 32'h22222222, 32'h0};
        vecs[5] = '{0, 0, 1, 1, 16'h0120, 16'h0127, 32'hAAAA5555, 32'h5555AAAA, 0, 16'h0, 16'h0, 32'h0, 32'h0};
        vecs[6] = '{1, 0, 1, 0, 16'hFFFC, 16'hFFFF, 32'hFFFFFFFF, 32'h0, 1, 16'hFFFC, 16'h0, 32'hFFFFFFFF, 32'h0};
        vecs[7] = '{1, 0, 1, 0, 16'h0001, 16'h0004, 32'h00000000, 32'h0, 1, 16'h0000, 16'h0, 32'h00000000, 32'h0};

        do_reset();

        // Table: single load events with the port idle.
        for (int v = 0; v < NV; v++) begin
            cyc();
            ld_valid = vecs[v].ld_valid; ecc_dis = vecs[v].dis;
            err_lo = vecs[v].lo; err_hi = vecs[v].hi;
            lsu_addr = vecs[v].addr; end_addr = vecs[v].eaddr;
            data_lo = vecs[v].dl; data_hi = vecs[v].dh;
            if (vecs[v].n > 0) push_exp(vecs[v].ea0, vecs[v].ed0);
            if (vecs[v].n > 1) push_exp(vecs[v].ea1, vecs[v].ed1);
            cyc();
            clear_inputs();
            wait_drain($sformatf("vec%0d", v), 10);
            @(negedge clk);
            check($sformatf("vec%0d_pending", v), {31'h0, pending}, 0);
        end

        // Capture-to-write latency is exactly one cycle.
        cyc();
        cap_lo(16'h0104, 32'hDEADBEEF);
        push_exp(16'h0104, 32'hDEADBEEF);
        @(negedge clk);
        check("lat_wren_n", {31'h0, wren}, 0);
        cyc();
        no_cap();
        @(negedge clk);
        check("lat_wren_n1", {31'h0, wren}, 1);
        check("lat_pending_n1", {31'h0, pending}, 1);
        cyc();
        @(negedge clk);
        check("lat_pending_n2", {31'h0, pending}, 0);

        // Starvation: busy from capture through cycle 19, release at cycle 20.
        cyc();
        busy = 1;
        cap_lo(16'h0500, 32'h0BADF00D);
        push_exp(16'h0500, 32'h0BADF00D);
        for (int c = 1; c < 20; c++) begin
            cyc();
            no_cap();
            @(negedge clk);
            check($sformatf("starve_stall_c%0d", c), {31'h0, stall}, (c >= 17) ? 1 : 0);
        end
        cyc();
        busy = 0;
        @(negedge clk);
        check("starve_wren_c20", {31'h0, wren}, 1);
        check("starve_stall_c20", {31'h0, stall}, 1);
        cyc();
        @(negedge clk);
        check("starve_stall_c21", {31'h0, stall}, 0);
        check("starve_pending_c21", {31'h0, pending}, 0);
        wait_drain("starve", 2);

        // Kill by stbuf drain to the same word, then same-cycle capture suppression.
        cyc();
        busy = 1;
        cap_lo(16'h0200, 32'h13572468);
        cyc();
        no_cap();
        busy = 0; stbuf_wr = 1; stbuf_addr = 16'h0202;
        @(negedge clk);
        check("kill_pending_c1", {31'h0, pending}, 1);
        cyc();
        clear_inputs();
        @(negedge clk);
        check("kill_pending_c2", {31'h0, pending}, 0);
        check("kill_stall_c2", {31'h0, stall}, 0);
        cyc();
        cap_lo(16'h0300, 32'h24681357);
        stbuf_wr = 1; stbuf_addr = 16'h0300;
        cyc();
        clear_inputs();
        @(negedge clk);
        check("supp_pending", {31'h0, pending}, 0);
        cyc();
        cap_lo(16'h0304, 32'h600DCAFE);
        push_exp(16'h0304, 32'h600DCAFE);
        cyc();
        no_cap();
        @(negedge clk);
        check("kill_idle_wren", {31'h0, wren}, 1);
        wait_drain("kill", 3);

        // Full queue: drop on a new address, merge on a queued address,
        // and push accepted alongside a pop.
        push_exp(16'h0400, 32'hDDDD0004);
        push_exp(16'h0500, 32'hBBBB0005);
        push_exp(16'h0700, 32'hEEEE0007);
        cyc();
        busy = 1;
        cap_lo(16'h0400, 32'hAAAA0004);
        cyc();
        cap_lo(16'h0500, 32'hBBBB0005);
        cyc();
        cap_lo(16'h0600, 32'hCCCC0006);
        @(negedge clk);
        check("full_drop_c2", {31'h0, drop}, 0);
        cyc();
        cap_lo(16'h0400, 32'hDDDD0004);
        @(negedge clk);
        check("full_drop_c3", {31'h0, drop}, 1);
        cyc();
        no_cap();
        @(negedge clk);
        check("merge_drop_c4", {31'h0, drop}, 0);
        check("merge_pending_c4", {31'h0, pending}, 1);
        cyc();
        busy = 0;
        cap_lo(16'h0700, 32'hEEEE0007);
        cyc();
        no_cap();
        @(negedge clk);
        check("pushpop_drop_c6", {31'h0, drop}, 0);
        wait_drain("full", 6);

        // ecc_disable after capture does not flush the queue.
        cyc();
        busy = 1;
        cap_lo(16'h0A04, 32'h55AA55AA);
        push_exp(16'h0A04, 32'h55AA55AA);
        cyc();
        no_cap();
        busy = 0; ecc_dis = 1;
        @(negedge clk);
        check("dis_wren", {31'h0, wren}, 1);
        cyc();
        ecc_dis = 0;
        wait_drain("dis", 3);

        // Reset in the middle of WAIT clears everything.
        cyc();
        busy = 1;
        cap_lo(16'h0C00, 32'h77777777);
        cyc();
        no_cap();
        cyc();
        do_reset();
        repeat (3) begin
            @(negedge clk);
            check("post_rst_pending", {31'h0, pending}, 0);
        end

`ifdef RV_ECC_SCRUB_CNT_EN
        // Five accepted captures saturate a 2-bit counter.
        cyc();
        cap_lo(16'h0800, 32'h00000800);
        push_exp(16'h0800, 32'h00000800);
        cyc();
        ld_valid = 1; err_lo = 1; err_hi = 1;
        lsu_addr = 16'h0806; end_addr = 16'h0809;
        data_lo = 32'h00000804; data_hi = 32'h00000808;
        push_exp(16'h0804, 32'h00000804);
        push_exp(16'h0808, 32'h00000808);
        @(negedge clk);
        check("cnt_after1", {30'h0, err_cnt}, 1);
        cyc();
        cap_lo(16'h0900, 32'h00000900);
        push_exp(16'h0900, 32'h00000900);
        @(negedge clk);
        check("cnt_after3", {30'h0, err_cnt}, 3);
        cyc();
        cap_lo(16'h0A00, 32'h00000A00);
        push_exp(16'h0A00, 32'h00000A00);
        cyc();
        no_cap();
        @(negedge clk);
        check("cnt_sat", {30'h0, err_cnt}, 3);
        wait_drain("cnt", 8);
`endif

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
